// File: rtl/nonce_dispatcher.sv
// Job front end for a multi-core miner: broadcasts one job, steps interleaved nonces per core,
// maps pipeline-delayed core hits back to golden nonces and queues them in a result FIFO.
module nonce_dispatcher #(
    parameter int unsigned CORE_LOG2    = 2,
    parameter int unsigned LOOP_LOG2    = 0,
    parameter int unsigned PIPE_STEPS   = 66,
    parameter int unsigned RESULT_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            work_valid,
    output logic                            work_ready,
    input  logic [255:0]                    work_midstate,
    input  logic [95:0]                     work_data,
    input  logic [31:0]                     work_nonce_start,
    input  logic [31:0]                     work_nonce_end,
    output logic [255:0]                    core_midstate,
    output logic [95:0]                     core_data,
    output logic [32*(2**CORE_LOG2)-1:0]    core_nonce,
    input  logic [(2**CORE_LOG2)-1:0]       core_hit,
    output logic                            result_valid,
    input  logic                            result_ready,
    output logic [31:0]                     result_nonce,
    output logic                            busy,
    output logic                            done,
    output logic                            overflow
);

    localparam int unsigned NUM_CORES = 2 ** CORE_LOG2;
    localparam int unsigned PTR_W     = $clog2(RESULT_DEPTH);
    localparam int unsigned LS_W      = 34;
    localparam logic [31:0] LOW_MASK  = 32'(NUM_CORES - 1);
    localparam logic [5:0]  SUB_MAX   = 6'((2 ** LOOP_LOG2) - 1);
    localparam logic [31:0] DRAIN_MAX = 32'(PIPE_STEPS - 1);
    localparam logic [LS_W-1:0] PIPE_LS = LS_W'(PIPE_STEPS);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SCAN  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic [31:0]                  base_q, base_d;
    logic [31:0]                  last_q, last_d;
    logic [31:0]                  step_q, step_d;
    logic [5:0]                   sub_q, sub_d;
    logic [LS_W-1:0]              ls_q, ls_d;
    logic [31:0]                  drain_q, drain_d;
    logic                         done_q, done_d;
    logic                         ovf_q, ovf_d;
    logic [255:0]                 mid_q;
    logic [95:0]                  data_q;
    logic [32*NUM_CORES-1:0]      nonce_q, nonce_d;
    logic                         load_nonce;
    logic [NUM_CORES-1:0]         pend_v_q, pend_v_d;
    logic [31:0]                  pend_n_q [NUM_CORES];
    logic [31:0]                  pend_n_d [NUM_CORES];
    logic [NUM_CORES-1:0]         free;

    logic [31:0]                  fifo_mem [RESULT_DEPTH];
    logic [PTR_W:0]               wptr_q, rptr_q;
    logic                         fifo_full, fifo_empty, push, pop, found;
    logic [31:0]                  push_nonce;

    logic                         accept, wrap, hit_en;
    logic [31:0]                  start_base, start_last, golden_base;

    assign work_ready  = (state_q != ST_DRAIN);
    assign accept      = work_valid && work_ready;
    assign wrap        = (sub_q == SUB_MAX);
    assign start_base  = work_nonce_start & ~LOW_MASK;
    // Modular difference keeps wrap-around ranges legal.
    assign start_last  = ((work_nonce_end & ~LOW_MASK) - start_base) >> CORE_LOG2;
    assign hit_en      = (state_q != ST_IDLE) && (ls_q >= PIPE_LS);
    assign golden_base = base_q + (32'(ls_q - PIPE_LS) << CORE_LOG2);

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        last_d     = last_q;
        step_d     = step_q;
        sub_d      = sub_q;
        ls_d       = ls_q;
        drain_d    = drain_q;
        done_d     = 1'b0;
        load_nonce = 1'b0;
        if (accept) begin
            state_d    = ST_SCAN;
            base_d     = start_base;
            last_d     = start_last;
            step_d     = 32'd0;
            sub_d      = 6'd0;
            ls_d       = '0;
            drain_d    = 32'd0;
            load_nonce = 1'b1;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    sub_d = wrap ? 6'd0 : sub_q + 6'd1;
                    if (wrap) begin
                        ls_d = ls_q + LS_W'(1);
                        if (step_q == last_q) begin
                            drain_d = 32'd0;
                            if (PIPE_STEPS == 0) begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_DRAIN;
                            end
                        end else begin
                            step_d     = step_q + 32'd1;
                            load_nonce = 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    sub_d = wrap ? 6'd0 : sub_q + 6'd1;
                    if (wrap) begin
                        ls_d = ls_q + LS_W'(1);
                        if (drain_q == DRAIN_MAX) begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            drain_d = drain_q + 32'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nonce_d = nonce_q;
        if (load_nonce) begin
            for (int i = 0; i < NUM_CORES; i++) begin
                nonce_d[32*i +: 32] = base_d + (step_d << CORE_LOG2) + 32'(i);
            end
        end
    end

    assign fifo_empty = (wptr_q == rptr_q);
    assign fifo_full  = (wptr_q[PTR_W] != rptr_q[PTR_W]) &&
                        (wptr_q[PTR_W-1:0] == rptr_q[PTR_W-1:0]);
    assign pop        = result_ready && !fifo_empty;

    // Lowest-index full pending register wins the single FIFO write port.
    always_comb begin
        found      = 1'b0;
        push_nonce = 32'd0;
        free       = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (pend_v_q[i] && !found) begin
                found      = 1'b1;
                push_nonce = pend_n_q[i];
                free[i]    = !fifo_full || pop;
            end
        end
        push = found && (!fifo_full || pop);
    end

    always_comb begin
        ovf_d = ovf_q;
        for (int i = 0; i < NUM_CORES; i++) begin
            pend_v_d[i] = pend_v_q[i] && !free[i];
            pend_n_d[i] = pend_n_q[i];
            if (hit_en && core_hit[i]) begin
                if (!pend_v_d[i]) begin
                    pend_v_d[i] = 1'b1;
                    pend_n_d[i] = golden_base + 32'(i);
                end else begin
                    ovf_d = 1'b1;
                end
            end
        end
        if (accept) begin
            pend_v_d = '0;
            ovf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= 32'd0;
            last_q   <= 32'd0;
            step_q   <= 32'd0;
            sub_q    <= 6'd0;
            ls_q     <= '0;
            drain_q  <= 32'd0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            mid_q    <= 256'd0;
            data_q   <= 96'd0;
            nonce_q  <= '0;
            pend_v_q <= '0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_n_q[i] <= 32'd0;
            end
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            last_q   <= last_d;
            step_q   <= step_d;
            sub_q    <= sub_d;
            ls_q     <= ls_d;
            drain_q  <= drain_d;
            done_q   <= done_d;
            ovf_q    <= ovf_d;
            nonce_q  <= nonce_d;
            pend_v_q <= pend_v_d;
            for (int i = 0; i < NUM_CORES; i++) begin
                pend_n_q[i] <= pend_n_d[i];
            end
            if (accept) begin
                mid_q  <= work_midstate;
                data_q <= work_data;
            end
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wptr_q[PTR_W-1:0]] <= push_nonce;
        end
    end

    assign core_midstate = mid_q;
    assign core_data     = data_q;
    assign core_nonce    = nonce_q;
    assign result_valid  = !fifo_empty;
    assign result_nonce  = fifo_mem[rptr_q[PTR_W-1:0]];
    assign busy          = (state_q != ST_IDLE);
    assign done          = done_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_nonce_dispatcher.sv
// Bench for nonce_dispatcher: three configurations share stimulus; each test resets all of them
// and checks one instance against a cycle-indexed reference model.
module tb_nonce_dispatcher;

    localparam int PIPE = 4;

    logic         clk = 1'b0;
    logic         rst_n, work_valid, result_ready;
    logic [255:0] work_midstate;
    logic [95:0]  work_data;
    logic [31:0]  work_nonce_start, work_nonce_end;
    logic [3:0]   core_hit;

    logic a_ready, a_rv, a_busy, a_done, a_ovf;
    logic b_ready, b_rv, b_busy, b_done, b_ovf;
    logic c_ready, c_rv, c_busy, c_done, c_ovf;
    logic [255:0] a_mid, b_mid, c_mid;
    logic [95:0]  a_data, b_data, c_data;
    logic [127:0] a_nonce;
    logic [31:0]  b_nonce, c_nonce, a_rn, b_rn, c_rn;

    int checks = 0;
    int errors = 0;
    int hk[$];
    logic [3:0] hm[$];
    int pops[$];

    always #5 clk = ~clk;

    nonce_dispatcher #(.CORE_LOG2(2), .LOOP_LOG2(0), .PIPE_STEPS(PIPE), .RESULT_DEPTH(4)) u_a (
        .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(a_ready),
        .work_midstate(work_midstate), .work_data(work_data),
        .work_nonce_start(work_nonce_start), .work_nonce_end(work_nonce_end),
        .core_midstate(a_mid), .core_data(a_data), .core_nonce(a_nonce), .core_hit(core_hit),
        .result_valid(a_rv), .result_ready(result_ready), .result_nonce(a_rn),
        .busy(a_busy), .done(a_done), .overflow(a_ovf));

    nonce_dispatcher #(.CORE_LOG2(0), .LOOP_LOG2(2), .PIPE_STEPS(PIPE), .RESULT_DEPTH(4)) u_b (
        .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(b_ready),
        .work_midstate(work_midstate), .work_data(work_data),
        .work_nonce_start(work_nonce_start), .work_nonce_end(work_nonce_end),
        .core_midstate(b_mid), .core_data(b_data), .core_nonce(b_nonce), .core_hit(core_hit[0:0]),
        .result_valid(b_rv), .result_ready(result_ready), .result_nonce(b_rn),
        .busy(b_busy), .done(b_done), .overflow(b_ovf));

    nonce_dispatcher #(.CORE_LOG2(0), .LOOP_LOG2(0), .PIPE_STEPS(PIPE), .RESULT_DEPTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .work_valid(work_valid), .work_ready(c_ready),
        .work_midstate(work_midstate), .work_data(work_data),
        .work_nonce_start(work_nonce_start), .work_nonce_end(work_nonce_end),
        .core_midstate(c_mid), .core_data(c_data), .core_nonce(c_nonce), .core_hit(core_hit[0:0]),
        .result_valid(c_rv), .result_ready(result_ready), .result_nonce(c_rn),
        .busy(c_busy), .done(c_done), .overflow(c_ovf));

    task do_reset();
        @(negedge clk);
        rst_n = 1'b0; work_valid = 1'b0; core_hit = 4'd0; result_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Returns at the negedge of the first cycle after the accepting edge.
    task accept(input logic [31:0] s, input logic [31:0] e);
        work_nonce_start = s;
        work_nonce_end   = e;
        for (int j = 0; j < 8; j++) work_midstate[32*j +: 32] = $urandom;
        for (int j = 0; j < 3; j++) work_data[32*j +: 32] = $urandom;
        work_valid = 1'b1;
        @(negedge clk);
        work_valid = 1'b0;
    endtask

    task test_reset();
        rst_n = 1'b0; work_valid = 1'b0; core_hit = 4'd0; result_ready = 1'b1;
        work_midstate = '0; work_data = '0; work_nonce_start = '0; work_nonce_end = '0;
        repeat (2) @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", a_ready); end
        checks++; if (a_rv !== 1'b0 || a_done !== 1'b0 || a_ovf !== 1'b0) begin
            errors++; $display("FAIL reset_flags got rv=%b done=%b ovf=%b want 0", a_rv, a_done, a_ovf); end
        checks++; if (a_nonce !== 128'd0 || a_mid !== 256'd0 || a_data !== 96'd0) begin
            errors++; $display("FAIL reset_core got nonce=%h want 0", a_nonce); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Runs one job on instance A with hits taken from hk/hm; model indexes cycles from acceptance.
    task run_a(input string name, input logic [31:0] s, input logic [31:0] e, input int extra);
        logic [31:0] base, last, st, exp_n;
        logic [31:0] exp_q[$];
        logic [3:0]  m;
        int total;
        base  = s & ~32'd3;
        last  = ((e & ~32'd3) - base) >> 2;
        total = int'(last) + 1 + PIPE;
        pops.delete();
        accept(s, e);
        for (int k = 0; k < total + extra; k++) begin
            if (k == 0) begin
                checks++; if (a_mid !== work_midstate || a_data !== work_data) begin
                    errors++; $display("FAIL %s broadcast got %h want %h", name, a_data, work_data); end
            end
            checks++; if (a_busy !== (k < total)) begin
                errors++; $display("FAIL %s busy k=%0d got %b want %b", name, k, a_busy, k < total); end
            checks++; if (a_done !== (k == total)) begin
                errors++; $display("FAIL %s done k=%0d got %b want %b", name, k, a_done, k == total); end
            checks++; if (a_ovf !== 1'b0) begin
                errors++; $display("FAIL %s overflow k=%0d got %b want 0", name, k, a_ovf); end
            st = (32'(k) < last) ? 32'(k) : last;
            for (int i = 0; i < 4; i++) begin
                exp_n = base + (st << 2) + 32'(i);
                checks++; if (a_nonce[32*i +: 32] !== exp_n) begin
                    errors++; $display("FAIL %s nonce k=%0d core=%0d got %h want %h",
                                       name, k, i, a_nonce[32*i +: 32], exp_n); end
            end
            if (a_rv === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL %s spurious_result k=%0d got %h want none", name, k, a_rn);
                end else begin
                    if (a_rn !== exp_q[0]) begin
                        errors++; $display("FAIL %s result k=%0d got %h want %h", name, k, a_rn, exp_q[0]); end
                    void'(exp_q.pop_front());
                end
                pops.push_back(k);
            end
            m = 4'd0;
            foreach (hk[j]) if (hk[j] == k) m = m | hm[j];
            core_hit = m;
            if (k >= PIPE && k < total)
                for (int i = 0; i < 4; i++)
                    if (m[i]) exp_q.push_back(base + (32'(k - PIPE) << 2) + 32'(i));
            @(negedge clk);
        end
        core_hit = 4'd0;
        checks++; if (exp_q.size() != 0) begin
            errors++; $display("FAIL %s missing_results got %0d left want 0", name, exp_q.size()); end
    endtask

    task test_single_core();
        logic [31:0] tgt;
        int khit;
        tgt = 32'h0e33337a;
        khit = -1;
        do_reset();
        accept(tgt - 32'd256, tgt);
        for (int k = 0; k < 266; k++) begin
            if (c_nonce === tgt && khit < 0) begin
                khit = k + PIPE;
                checks++; if (k != 256) begin errors++; $display("FAIL single_issue got k=%0d want 256", k); end
            end
            if (k == 260) begin
                checks++; if (c_busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", c_busy); end
            end
            if (k == 261) begin
                checks++; if (c_done !== 1'b1 || c_busy !== 1'b0) begin
                    errors++; $display("FAIL single_done got done=%b busy=%b want 1 0", c_done, c_busy); end
                checks++; if (c_rv !== 1'b0) begin errors++; $display("FAIL single_latency got %b want 0", c_rv); end
            end
            if (k == 262) begin
                checks++; if (c_rv !== 1'b1 || c_rn !== tgt) begin
                    errors++; $display("FAIL single_result got %b %h want 1 %h", c_rv, c_rn, tgt); end
            end
            core_hit = {3'd0, k == khit};
            @(negedge clk);
        end
        core_hit = 4'd0;
    endtask

    task test_four_cores();
        do_reset();
        hk.delete(); hm.delete();
        hk.push_back(PIPE + 2); hm.push_back(4'b1000);
        run_a("four_cores", 32'h102, 32'h10c, 4);
    endtask

    task test_simultaneous();
        do_reset();
        hk.delete(); hm.delete();
        hk.push_back(6); hm.push_back(4'b0101);
        run_a("simultaneous", 32'h2000, 32'h2020, 2);
        checks++; if (pops.size() != 2 || pops[1] != pops[0] + 1) begin
            errors++; $display("FAIL simultaneous_order got %0d pops want 2 consecutive", pops.size()); end
    endtask

    task test_random();
        logic [31:0] s, e;
        int len;
        for (int n = 0; n < 5; n++) begin
            do_reset();
            s   = $urandom;
            len = $urandom_range(0, 10);
            e   = (s & ~32'd3) + (32'(len) << 2) + 32'($urandom_range(0, 3));
            hk.delete(); hm.delete();
            for (int k = 0; k < len + PIPE + 3; k++)
                if ($urandom_range(0, 2) == 0) begin
                    hk.push_back(k); hm.push_back(4'b0001 << $urandom_range(0, 3));
                end
            run_a("random", s, e, 4);
        end
    endtask

    task test_back_pressure();
        logic [31:0] got[$];
        logic [31:0] want[5];
        want = '{32'd5, 32'd9, 32'd13, 32'd17, 32'd21};
        do_reset();
        result_ready = 1'b0;
        accept(32'h0, 32'h100);
        for (int k = 0; k < 12; k++) begin
            if (k == 10) begin
                checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL bp_early_ovf got %b want 0", a_ovf); end
            end
            if (k == 11) begin
                checks++; if (a_ovf !== 1'b1 || a_rv !== 1'b1) begin
                    errors++; $display("FAIL bp_ovf got ovf=%b rv=%b want 1 1", a_ovf, a_rv); end
            end
            core_hit = (k >= 5 && k <= 10) ? 4'b0010 : 4'd0;
            @(negedge clk);
        end
        core_hit = 4'd0;
        result_ready = 1'b1;
        for (int j = 0; j < 12; j++) begin
            if (a_rv === 1'b1) got.push_back(a_rn);
            @(negedge clk);
        end
        checks++; if (got.size() != 5) begin errors++; $display("FAIL bp_count got %0d want 5", got.size()); end
        for (int j = 0; j < 5 && j < got.size(); j++) begin
            checks++; if (got[j] !== want[j]) begin
                errors++; $display("FAIL bp_value idx=%0d got %h want %h", j, got[j], want[j]); end
        end
        accept(32'h200, 32'h210);
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL bp_ovf_clear got %b want 0", a_ovf); end
    endtask

    task test_wrap_preempt();
        logic [31:0] exp_n;
        logic [31:0] got[$];
        do_reset();
        accept(32'hfffffff8, 32'h00000004);
        for (int k = 0; k < 19; k++) begin
            exp_n = 32'hfffffff8 + 32'((k < 12) ? k : 12);
            checks++; if (c_nonce !== exp_n) begin
                errors++; $display("FAIL wrap_nonce k=%0d got %h want %h", k, c_nonce, exp_n); end
            checks++; if (c_busy !== (k < 17) || c_done !== (k == 17)) begin
                errors++; $display("FAIL wrap_state k=%0d got busy=%b done=%b", k, c_busy, c_done); end
            @(negedge clk);
        end
        accept(32'hfffffff8, 32'h00000004);
        repeat (5) @(negedge clk);
        checks++; if (c_nonce !== 32'hfffffffd) begin
            errors++; $display("FAIL preempt_step5 got %h want fffffffd", c_nonce); end
        accept(32'h5000, 32'h5010);
        for (int k = 0; k < 12; k++) begin
            if (k < 2) begin
                checks++; if (c_nonce !== 32'h5000 + 32'(k) || c_busy !== 1'b1) begin
                    errors++; $display("FAIL preempt_nonce k=%0d got %h want %h", k, c_nonce, 32'h5000 + 32'(k)); end
            end
            if (c_rv === 1'b1) got.push_back(c_rn);
            core_hit = {3'd0, k <= PIPE};
            @(negedge clk);
        end
        core_hit = 4'd0;
        checks++; if (got.size() != 1 || got[0] !== 32'h5000) begin
            errors++; $display("FAIL preempt_results got %0d entries want one 00005000", got.size()); end
    endtask

    task test_loop_reset();
        do_reset();
        accept(32'h40, 32'h50);
        for (int k = 0; k < 21; k++) begin
            checks++; if (b_nonce !== 32'h40 + 32'(k / 4)) begin
                errors++; $display("FAIL loop_hold k=%0d got %h want %h", k, b_nonce, 32'h40 + 32'(k / 4)); end
            if (k == 19) begin
                checks++; if (b_rv !== 1'b1 || b_rn !== 32'h40) begin
                    errors++; $display("FAIL loop_result got %b %h want 1 00000040", b_rv, b_rn); end
            end
            core_hit = {3'd0, k == 17};
            @(negedge clk);
        end
        core_hit = 4'd0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (b_busy !== 1'b0 || b_nonce !== 32'd0 || b_mid !== 256'd0 || b_data !== 96'd0) begin
            errors++; $display("FAIL async_reset got busy=%b nonce=%h want 0 0", b_busy, b_nonce); end
        checks++; if (b_rv !== 1'b0 || b_done !== 1'b0 || b_ovf !== 1'b0) begin
            errors++; $display("FAIL async_reset_flags got rv=%b done=%b ovf=%b", b_rv, b_done, b_ovf); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_single_core();
        test_four_cores();
        test_simultaneous();
        test_random();
        test_back_pressure();
        test_wrap_preempt();
        test_loop_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nonce_dispatcher.md
Name: nonce_dispatcher

Overview:
- Work-distribution front end for a multi-core mining top.
- Accepts one job (midstate, 96-bit data tail, nonce range) and broadcasts midstate/data to NUM_CORES = 2^CORE_LOG2 hashing cores.
- Steps an interleaved nonce per core, converts pipeline-delayed core hits back into golden nonces, and queues them through a result FIFO.
- Generalises the single-core, free-running nonce drive: bounded ranges, multi-core interleave, latency correction, preemption.

Parameters:
- CORE_LOG2, 2, log2 of core count; NUM_CORES = 2^CORE_LOG2 (1..16 cores).
- LOOP_LOG2, 0, each nonce step lasts 2^LOOP_LOG2 clk cycles (0..5).
- PIPE_STEPS, 66, core latency in steps between nonce issue and hit assertion.
- RESULT_DEPTH, 4, result FIFO entries (power of two, ≥2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- work_valid  in  1  job offered.
- work_ready  out  1  job accepted when valid&ready.
- work_midstate  in  256  SHA-256 midstate.
- work_data  in  96  header tail (time, bits, merkle tail).
- work_nonce_start  in  32  first nonce; low CORE_LOG2 bits ignored (treated 0).
- work_nonce_end  in  32  last nonce base, inclusive.
- core_midstate  out  256  registered broadcast midstate.
- core_data  out  96  registered broadcast data.
- core_nonce  out  32*NUM_CORES  core i slice [32i+31:32i].
- core_hit  in  NUM_CORES  core i found a hit (one-cycle pulse).
- result_valid  out  1  FIFO non-empty.
- result_ready  in  1  consumer pops on valid&ready.
- result_nonce  out  32  golden nonce at FIFO head.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when DRAIN completes.
- overflow  out  1  sticky: a hit was dropped; cleared only by reset or job accept.

Behaviour:
- Reset: state IDLE; core_midstate, core_data, core_nonce = 0; result_valid, busy, done, overflow = 0; FIFO empty; pending regs cleared.
- States: IDLE, SCAN, DRAIN.
- work_ready = 1 in IDLE and SCAN, 0 in DRAIN.
- Accept at edge T (any state with ready):
  - Latch job; base = start & ~(NUM_CORES-1); step = 0; subcycle = 0.
  - last = ((end & ~(NUM_CORES-1)) - base) mod 2^32 >> CORE_LOG2, so wrap-around ranges are legal.
  - Clear pending regs and overflow; FIFO is NOT flushed.
  - From T+1: core_midstate/data updated; core_nonce[i] = base + (step<<CORE_LOG2) + i, mod 2^32.
  - state = SCAN.
- SCAN:
  - subcycle counts 0..2^LOOP_LOG2-1; step increments when subcycle wraps.
  - On the wrap with step == last: state = DRAIN; core_nonce holds the final value.
- DRAIN:
  - Counts PIPE_STEPS further steps, then state = IDLE with done = 1 for one cycle.
- Hit attribution:
  - Logical step counter ls continues incrementing through DRAIN.
  - core_hit[i] sampled in SCAN/DRAIN with ls ≥ PIPE_STEPS yields golden = base + ((ls - PIPE_STEPS)<<CORE_LOG2) + i.
  - Hits in IDLE or with ls < PIPE_STEPS are ignored. This also discards stale hits after preemption.
- Pending regs:
  - One per core, holding a valid flag and a nonce.
  - A hit while that core's reg is full is dropped and sets overflow.
- Arbiter:
  - Each cycle, the lowest-index full pending reg moves into the FIFO if not full.
  - Its pending reg frees that cycle, and a same-cycle new hit on that core is accepted.
  - FIFO full: nothing moves.
- FIFO:
  - First-word fall-through; result_nonce valid whenever result_valid.
  - Push and pop in the same cycle is allowed when full or empty-with-push (no bypass: a push into an empty FIFO is visible the next cycle).
- Minimum hit-to-result_valid latency: 2 cycles.
- Preemption: a job accepted in SCAN restarts immediately per the Accept rules; results already queued remain.
- Async reset mid-scan returns everything to reset values immediately.

Test Plan:
- Single core: CORE_LOG2=0, LOOP_LOG2=0, PIPE_STEPS=4, start=0x0e33337a-256, end=0x0e33337a.
  - Stimulus: core_hit pulse 4 cycles after core_nonce==0x0e33337a.
  - Required: result_nonce=0x0e33337a, then done 4 steps after the last issue, busy falls.
- Four cores: CORE_LOG2=2, start=0x100, end=0x10c.
  - Required: cores show 0x100..0x103 at step 0 and 0x10c..0x10f at the last step.
  - Stimulus: hit on core 3 at ls=PIPE_STEPS+2.
  - Required: result 0x10b.
- Simultaneous hits on cores 0 and 2, result_ready=1.
  - Required: FIFO order core0 nonce then core2 nonce on consecutive cycles; overflow stays 0.
- Back-pressure: result_ready=0, RESULT_DEPTH=4, 6 hits on core 1 spaced 1 step apart.
  - Required: 4 queued, pending holds 1, 6th hit sets overflow.
- Wrap and preempt.
  - Stimulus: start=0xfffffff8, end=0x00000004, CORE_LOG2=0.
  - Required: nonces 0xfffffff8 → 0x00000004 (13 steps).
  - Stimulus: re-accept new job at step 5.
  - Required: core_nonce jumps to new base next cycle, old-job hits ignored.
- LOOP_LOG2=2:
  - Required: each core_nonce value held exactly 4 cycles; pulse rst_n low mid-SCAN → all outputs zero asynchronously.
